// File: rtl/matrix_mult_pkg.sv
// Shared defaults and the accumulator width helper for the matrix_mult datapath.
package matrix_mult_pkg;

  localparam int MM_N           = 4;
  localparam int MM_WIDTH       = 16;
  localparam int MM_PIPE_STAGES = 2;

  // Width needed to add N full-width products without losing the carry.
  function automatic int mm_acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_dot.sv
// One pipelined dot product of an A row and a B column, plus trailing delay stages.
// Saturates instead of wrapping when MATRIX_MULT_SATURATE_EN is defined.
module matrix_mult_dot
  import matrix_mult_pkg::*;
#(
  parameter int N           = MM_N,
  parameter int WIDTH       = MM_WIDTH,
  parameter int PIPE_STAGES = MM_PIPE_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a_row [N],
  input  logic [WIDTH-1:0]   b_col [N],
  output logic [2*WIDTH-1:0] c
);

  localparam int PW   = 2 * WIDTH;
  localparam int AW   = mm_acc_width(WIDTH, N);
  localparam int POST = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  logic [PW-1:0] prod   [N];
  logic [PW-1:0] term   [N];
  logic [AW-1:0] sum;
  logic [PW-1:0] res;
  logic [PW-1:0] post_q [POST];

  always_comb begin
    for (int k = 0; k < N; k++) prod[k] = PW'(a_row[k]) * PW'(b_col[k]);
  end

  // A single-stage build has no room for a product register, so the sum reads the multipliers directly.
  if (PIPE_STAGES == 1) begin : g_no_prod_reg
    always_comb begin
      for (int k = 0; k < N; k++) term[k] = prod[k];
    end
  end else begin : g_prod_reg
    logic [PW-1:0] prod_q [N];

    always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) prod_q[k] <= rst ? '0 : prod[k];
    end

    always_comb begin
      for (int k = 0; k < N; k++) term[k] = prod_q[k];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + AW'(term[k]);
  end

`ifdef MATRIX_MULT_SATURATE_EN
  always_comb res = (sum > AW'({PW{1'b1}})) ? '1 : sum[PW-1:0];
`else
  // Carry bits above the result width are deliberately dropped (modulo wrap).
  logic [AW-1:0] unused_sum_hi;
  assign unused_sum_hi = sum >> PW;
  always_comb res = sum[PW-1:0];
`endif

  // First entry holds the adder result; any further entries are plain delay on C.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < POST; s++) post_q[s] <= '0;
    end else begin
      post_q[0] <= res;
      for (int s = 1; s < POST; s++) post_q[s] <= post_q[s-1];
    end
  end

  assign c = post_q[POST-1];

endmodule

// File: rtl/matrix_mult.sv
// Fully parallel pipelined unsigned N x N matrix multiplier, C = A * B.
// Optional feature macro: MATRIX_MULT_SATURATE_EN (saturate instead of wrap).
module matrix_mult
  import matrix_mult_pkg::*;
#(
  parameter int N           = MM_N,
  parameter int WIDTH       = MM_WIDTH,
  parameter int PIPE_STAGES = MM_PIPE_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A [N][N],
  input  logic [WIDTH-1:0]   B [N][N],
  output logic [2*WIDTH-1:0] C [N][N]
);

  // One dot-product lane per output element, fed by row i of A and column j of B.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [WIDTH-1:0] a_row [N];
      logic [WIDTH-1:0] b_col [N];

      always_comb begin
        for (int k = 0; k < N; k++) begin
          a_row[k] = A[i][k];
          b_col[k] = B[k][j];
        end
      end

      matrix_mult_dot #(
        .N          (N),
        .WIDTH      (WIDTH),
        .PIPE_STAGES(PIPE_STAGES)
      ) u_dot (
        .clk  (clk),
        .rst  (rst),
        .a_row(a_row),
        .b_col(b_col),
        .c    (C[i][j])
      );
    end
  end

endmodule

// File: tb/tb_matrix_mult.sv
// Scoreboard bench for matrix_mult: stimulus pushes expected products, a monitor pops and compares.
module tb_matrix_mult;

  localparam int N = 4;
  localparam int W = 16;
  localparam int P = 2;

  typedef logic [N-1:0][N-1:0][W-1:0]   opnd_t;
  typedef logic [N-1:0][N-1:0][2*W-1:0] res_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   A [N][N];
  logic [W-1:0]   B [N][N];
  logic [2*W-1:0] C [N][N];

  res_t  exp_q  [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  matrix_mult #(
    .N          (N),
    .WIDTH      (W),
    .PIPE_STAGES(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .C  (C)
  );

  always #5 clk = ~clk;

  // Reference product straight from the definition, in 64-bit arithmetic.
  function automatic res_t model(input opnd_t a, input opnd_t b);
    res_t        r;
    logic [63:0] s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + 64'(a[i][k]) * 64'(b[k][j]);
`ifdef MATRIX_MULT_SATURATE_EN
        r[i][j] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
        r[i][j] = s[31:0];
`endif
      end
    end
    return r;
  endfunction

  function automatic opnd_t scaled_ident(input int scale);
    opnd_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = (i == j) ? W'(scale) : '0;
    return m;
  endfunction

  function automatic opnd_t filled(input logic [W-1:0] v);
    opnd_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  // mode 0: full-range random, 1: small values, 2: mix of random and all-ones
  function automatic opnd_t rand_mat(input int mode);
    opnd_t m;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          1:       m[i][j] = W'($urandom_range(0, 15));
          2:       m[i][j] = ($urandom_range(0, 1) == 1) ? {W{1'b1}} : W'($urandom);
          default: m[i][j] = W'($urandom);
        endcase
      end
    end
    return m;
  endfunction

  // Drives one operand pair for the next edge. A reset wipes every in-flight expectation.
  task automatic applyStimulus(input opnd_t a, input opnd_t b, input logic r, input string name);
    @(negedge clk);
    rst = r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = a[i][j];
        B[i][j] = b[i][j];
      end
    end
    if (r) begin
      foreach (exp_q[k]) exp_q[k] = '0;
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model(a, b));
    end
    name_q.push_back(name);
  endtask

  task automatic checkOutput();
    res_t  expv;
    res_t  got;
    string nm;
    bit    reported;
    expv = exp_q.pop_front();
    nm   = name_q.pop_front();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) got[i][j] = C[i][j];
    checks++;
    if (got !== expv) begin
      failures++;
      reported = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (!reported && got[i][j] !== expv[i][j]) begin
            $display("[TB] FAIL %s: C[%0d][%0d] got %h expected %h", nm, i, j, got[i][j], expv[i][j]);
            reported = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: once P samples are queued, the oldest one is the value now on C.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= P) checkOutput();
    end
  end

  initial begin
    opnd_t a;
    opnd_t b;
    rst = 1'b1;

    a = rand_mat(0);
    b = rand_mat(0);
    if (a == '0) a = filled(16'h0001);
    if (b == '0) b = filled(16'h0001);
    repeat (3) applyStimulus(a, b, 1'b1, "reset");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) a[i][j] = W'(i + j);
    repeat (4) applyStimulus(a, scaled_ident(1), 1'b0, "identity");

    applyStimulus(scaled_ident(1), scaled_ident(2), 1'b0, "diag2");
    applyStimulus(scaled_ident(1), scaled_ident(3), 1'b0, "diag3");
    applyStimulus(scaled_ident(1), scaled_ident(5), 1'b0, "diag5");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) a[i][j] = W'(i * N + j + 1);
    repeat (3) applyStimulus(a, filled(16'h0001), 1'b0, "general");

    repeat (3) applyStimulus(filled(16'hFFFF), filled(16'hFFFF), 1'b0, "overflow");

    for (int c = 0; c < 20; c++)
      applyStimulus(rand_mat(c % 3), rand_mat((c + 1) % 3), (c == 10) ? 1'b1 : 1'b0, "midreset");

    for (int c = 0; c < 20; c++)
      applyStimulus(rand_mat(c % 3), rand_mat(2), 1'b0, "random");

    repeat (P) applyStimulus(rand_mat(1), rand_mat(1), 1'b0, "drain");

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
